// File: rtl/output64_if.sv
// Word handshake between the processing core (master) and the UART transmit block (slave).
interface output64_if;
    logic [63:0] dataOutput;
    logic        dataOutValid;
    logic        dataOutReady;

    modport master (output dataOutput, output dataOutValid, input dataOutReady);
    modport slave  (input dataOutput, input dataOutValid, output dataOutReady);
endinterface

// File: rtl/output64.sv
// 64-bit UART transmitter: frames a word stream with an 8x0xAA preamble and 8x0x55 terminator,
// sending every 64-bit burst MSB byte first as 8N1 bytes, back to back.
//
// state  | meaning
// IDLE   | line high, waiting for streamStart
// ACTIVE | accepting data words, one 8-byte burst per word
// SYNC   | sending the 8x0xAA preamble
// END    | sending the 8x0x55 terminator
module output64 #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BIT_RATE = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        streamStart,
    input  logic        streamStop,
    output64_if.slave   bus,
    output logic        dataOut64Done,
    output logic [1:0]  fsm_state,
    output logic [3:0]  byteCnt,
    output logic        uart_tx_pin
);
    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] CNT_LOAD  = CW'(CPB - 1);
    localparam logic [63:0]   SYNC_WORD = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0]   TERM_WORD = 64'h5555_5555_5555_5555;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_SYNC   = 2'b10,
        ST_END    = 2'b11
    } state_t;

    state_t        r_state;
    logic          r_busy;
    logic [63:0]   r_shift;
    logic [3:0]    r_bit_idx;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_byte_cnt;
    logic          r_tx;
    logic          r_done;
    logic          r_stop_pend;

    logic          w_bit_end;
    logic          w_burst_end;
    logic          w_load;
    logic [63:0]   w_load_word;
    state_t        w_state_nxt;
    logic [7:0]    w_cur_byte;

    assign w_cur_byte = r_shift[63:56];

    always_comb begin
        w_bit_end   = r_busy && (r_cnt == '0);
        w_burst_end = w_bit_end && (r_bit_idx == 4'd9) && (r_byte_cnt == 4'd7);
        w_load      = 1'b0;
        w_load_word = SYNC_WORD;
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (streamStart) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (w_burst_end) begin
                    if (r_stop_pend) begin
                        w_load      = 1'b1;
                        w_load_word = TERM_WORD;
                        w_state_nxt = ST_END;
                    end else begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                // A pending stop is honoured only once the serialiser is empty or finishing.
                if (!r_busy) begin
                    if (r_stop_pend) begin
                        w_load      = 1'b1;
                        w_load_word = TERM_WORD;
                        w_state_nxt = ST_END;
                    end else if (bus.dataOutValid) begin
                        w_load      = 1'b1;
                        w_load_word = bus.dataOutput;
                    end
                end else if (w_burst_end && r_stop_pend) begin
                    w_load      = 1'b1;
                    w_load_word = TERM_WORD;
                    w_state_nxt = ST_END;
                end
            end
            ST_END: begin
                if (w_burst_end) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_shift     <= '0;
            r_bit_idx   <= 4'd0;
            r_cnt       <= '0;
            r_byte_cnt  <= 4'd0;
            r_tx        <= 1'b1;
            r_done      <= 1'b0;
            r_stop_pend <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_burst_end && (r_state == ST_ACTIVE);

            if ((r_state == ST_END) && w_burst_end)
                r_stop_pend <= 1'b0;
            else if (streamStop && ((r_state == ST_SYNC) || (r_state == ST_ACTIVE)))
                r_stop_pend <= 1'b1;

            // A new burst starts on the same edge the previous stop bit ends.
            if (w_load) begin
                r_busy     <= 1'b1;
                r_shift    <= w_load_word;
                r_bit_idx  <= 4'd0;
                r_cnt      <= CNT_LOAD;
                r_byte_cnt <= 4'd0;
                r_tx       <= 1'b0;
            end else if (w_bit_end) begin
                r_cnt <= CNT_LOAD;
                if (r_bit_idx == 4'd9) begin
                    r_byte_cnt <= r_byte_cnt + 4'd1;
                    if (r_byte_cnt == 4'd7) begin
                        r_busy <= 1'b0;
                        r_tx   <= 1'b1;
                    end else begin
                        r_shift   <= {r_shift[55:0], 8'h00};
                        r_bit_idx <= 4'd0;
                        r_tx      <= 1'b0;
                    end
                end else begin
                    r_bit_idx <= r_bit_idx + 4'd1;
                    r_tx      <= (r_bit_idx == 4'd8) ? 1'b1 : w_cur_byte[r_bit_idx[2:0]];
                end
            end else if (r_busy) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign bus.dataOutReady = (r_state == ST_ACTIVE) && !r_busy && !r_stop_pend;
    assign dataOut64Done    = r_done;
    assign fsm_state        = r_state;
    assign byteCnt          = r_byte_cnt;
    assign uart_tx_pin      = r_tx;
endmodule

// File: tb/tb_output64.sv
// Directed bench for output64 at 10 clocks per bit: captures the pin and status per cycle,
// decodes bursts from the capture and compares against hand-written words and timings.
module tb_output64;
    logic       clk = 1'b0;
    logic       reset;
    logic       streamStart;
    logic       streamStop;
    logic       dataOut64Done;
    logic [1:0] fsm_state;
    logic [3:0] byteCnt;
    logic       uart_tx_pin;

    output64_if bus ();

    output64 #(.CLK_HZ(50_000_000), .BIT_RATE(5_000_000)) dut (
        .clk           (clk),
        .reset         (reset),
        .streamStart   (streamStart),
        .streamStop    (streamStop),
        .bus           (bus),
        .dataOut64Done (dataOut64Done),
        .fsm_state     (fsm_state),
        .byteCnt       (byteCnt),
        .uart_tx_pin   (uart_tx_pin)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic       cap_pin   [0:2047];
    logic       cap_done  [0:2047];
    logic       cap_ready [0:2047];
    logic [1:0] cap_state [0:2047];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Records one sample per negedge starting at the current one; ends on negedge n.
    task automatic capture(input int n, input int drop_valid_at, input int stop_at);
        for (int i = 0; i < n; i++) begin
            cap_pin[i]   = uart_tx_pin;
            cap_done[i]  = dataOut64Done;
            cap_ready[i] = bus.dataOutReady;
            cap_state[i] = fsm_state;
            if (i == drop_valid_at) bus.dataOutValid = 1'b0;
            if (i == stop_at) streamStop = 1'b1;
            else if (i == stop_at + 1) streamStop = 1'b0;
            @(negedge clk);
        end
    endtask

    function automatic logic [63:0] dec_word(input int base);
        logic [63:0] w;
        w = '0;
        for (int j = 0; j < 8; j++)
            for (int b = 0; b < 8; b++)
                w[56 - 8*j + b] = cap_pin[base + j*100 + (b+1)*10 + 5];
        return w;
    endfunction

    function automatic int frame_errs(input int base);
        int e;
        e = 0;
        for (int j = 0; j < 8; j++) begin
            if (cap_pin[base + j*100] !== 1'b0 || cap_pin[base + j*100 + 9] !== 1'b0) e++;
            for (int s = 90; s < 100; s++)
                if (cap_pin[base + j*100 + s] !== 1'b1) e++;
        end
        return e;
    endfunction

    function automatic int count_done(input int lo, input int hi);
        int c;
        c = 0;
        for (int i = lo; i <= hi; i++) if (cap_done[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_ready(input int lo, input int hi);
        int c;
        c = 0;
        for (int i = lo; i <= hi; i++) if (cap_ready[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic pulse_start(input logic with_stop);
        streamStart = 1'b1;
        streamStop  = with_stop;
        @(negedge clk);
        streamStart = 1'b0;
        streamStop  = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        streamStart      = 1'b0;
        streamStop       = 1'b0;
        bus.dataOutput   = '0;
        bus.dataOutValid = 1'b0;
        #1;
        check("rst_pin",   64'(uart_tx_pin), 64'd1);
        check("rst_state", 64'(fsm_state), 64'd0);
        check("rst_cnt",   64'(byteCnt), 64'd0);
        check("rst_ready", 64'(bus.dataOutReady), 64'd0);
        check("rst_done",  64'(dataOut64Done), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_state", 64'(fsm_state), 64'd0);

        // Stream start: preamble then ACTIVE with ready
        pulse_start(1'b0);
        check("start_state", 64'(fsm_state), 64'd2);
        check("start_pin",   64'(uart_tx_pin), 64'd0);
        capture(800, -1, -1);
        check("sync_word",   dec_word(0), 64'hAAAA_AAAA_AAAA_AAAA);
        check("sync_frame",  64'(frame_errs(0)), 64'd0);
        check("sync_nodone", 64'(count_done(0, 799)), 64'd0);
        check("sync_state",  64'(fsm_state), 64'd1);
        check("sync_ready",  64'(bus.dataOutReady), 64'd1);
        check("sync_cnt",    64'(byteCnt), 64'd8);

        // Single word
        bus.dataOutput   = 64'h0123_4567_89AB_CDEF;
        bus.dataOutValid = 1'b1;
        @(negedge clk);
        bus.dataOutValid = 1'b0;
        check("acc_pin",   64'(uart_tx_pin), 64'd0);
        check("acc_ready", 64'(bus.dataOutReady), 64'd0);
        check("acc_cnt",   64'(byteCnt), 64'd0);
        capture(800, -1, -1);
        check("w1_word",   dec_word(0), 64'h0123_4567_89AB_CDEF);
        check("w1_frame",  64'(frame_errs(0)), 64'd0);
        check("w1_early",  64'(count_done(0, 799)), 64'd0);
        check("w1_done",   64'(dataOut64Done), 64'd1);
        check("w1_cnt",    64'(byteCnt), 64'd8);
        check("w1_ready",  64'(bus.dataOutReady), 64'd1);
        check("w1_pin",    64'(uart_tx_pin), 64'd1);
        @(negedge clk);
        check("w1_done_1cyc", 64'(dataOut64Done), 64'd0);

        // Back-to-back words, second one is the terminator pattern and must pass through unfiltered
        bus.dataOutput   = 64'hFEDC_BA98_7654_3210;
        bus.dataOutValid = 1'b1;
        @(negedge clk);
        bus.dataOutput   = 64'h5555_5555_5555_5555;
        capture(1602, 801, -1);
        check("b2b_wordA",  dec_word(0), 64'hFEDC_BA98_7654_3210);
        check("b2b_wordB",  dec_word(801), 64'h5555_5555_5555_5555);
        check("b2b_frame",  64'(frame_errs(0) + frame_errs(801)), 64'd0);
        check("b2b_gap",    64'({cap_pin[799], cap_pin[800], cap_pin[801]}), 64'b110);
        check("b2b_rdy800", 64'({cap_ready[800], cap_ready[801]}), 64'b10);
        check("b2b_dones",  64'(count_done(0, 1601)), 64'd2);
        check("b2b_done_at",64'({cap_done[800], cap_done[1601]}), 64'b11);
        check("b2b_state",  64'(fsm_state), 64'd1);

        // Stop requested 300 cycles into a word
        bus.dataOutput   = 64'h00FF_00FF_1234_5678;
        bus.dataOutValid = 1'b1;
        @(negedge clk);
        bus.dataOutValid = 1'b0;
        capture(1600, -1, 300);
        check("stp_word",   dec_word(0), 64'h00FF_00FF_1234_5678);
        check("stp_term",   dec_word(800), 64'h5555_5555_5555_5555);
        check("stp_frame",  64'(frame_errs(0) + frame_errs(800)), 64'd0);
        check("stp_done",   64'({cap_done[800], 10'(count_done(0, 1599))}), 64'h401);
        check("stp_end_at", 64'(cap_state[800]), 64'd3);
        check("stp_noready",64'(count_ready(0, 1599)), 64'd0);
        check("stp_idle",   64'(fsm_state), 64'd0);
        check("stp_pin",    64'(uart_tx_pin), 64'd1);
        check("stp_cnt",    64'(byteCnt), 64'd8);

        // Start and stop together in IDLE: start wins
        pulse_start(1'b1);
        check("ss_state", 64'(fsm_state), 64'd2);
        capture(800, -1, -1);
        check("ss_sync",  dec_word(0), 64'hAAAA_AAAA_AAAA_AAAA);
        check("ss_active",64'(fsm_state), 64'd1);
        check("ss_ready", 64'(bus.dataOutReady), 64'd1);

        // Stop while ACTIVE and empty: terminator follows on the next edge
        streamStop = 1'b1;
        @(negedge clk);
        streamStop = 1'b0;
        check("is_ready", 64'(bus.dataOutReady), 64'd0);
        @(negedge clk);
        check("is_state", 64'(fsm_state), 64'd3);
        capture(800, -1, -1);
        check("is_term",  dec_word(0), 64'h5555_5555_5555_5555);
        check("is_idle",  64'(fsm_state), 64'd0);

        // Stop during SYNC: preamble then terminator directly, ready never raised
        pulse_start(1'b0);
        capture(1600, -1, 200);
        check("sy_sync",    dec_word(0), 64'hAAAA_AAAA_AAAA_AAAA);
        check("sy_term",    dec_word(800), 64'h5555_5555_5555_5555);
        check("sy_end_at",  64'(cap_state[800]), 64'd3);
        check("sy_noready", 64'(count_ready(0, 1599)), 64'd0);
        check("sy_nodone",  64'(count_done(0, 1599)), 64'd0);
        check("sy_idle",    64'(fsm_state), 64'd0);

        // Asynchronous reset in the middle of a byte
        pulse_start(1'b0);
        repeat (15) @(negedge clk);
        check("mr_pin_low", 64'(uart_tx_pin), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        check("mr_pin",   64'(uart_tx_pin), 64'd1);
        check("mr_state", 64'(fsm_state), 64'd0);
        check("mr_cnt",   64'(byteCnt), 64'd0);
        check("mr_ready", 64'(bus.dataOutReady), 64'd0);
        check("mr_done",  64'(dataOut64Done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("mr_after", 64'({fsm_state, uart_tx_pin}), 64'b001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/output64.md
# output64

Transmit-side counterpart of the 64-bit UART input path. Accepts 64-bit words over a valid/ready handshake and serialises each one as 8 UART bytes (8N1, MSB byte first) on one pin. Frames each stream with the same markers the receive side decodes: 8×0xAA sync preamble on start, 8×0x55 terminator on stop. Contains its own bit-level serialiser; sits between the processing core and the UART_TX hardware pin.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz
- BIT_RATE, 9600, UART baud rate; CPB = CLK_HZ/BIT_RATE, truncated, must be ≥ 2
- clk  input  1  50MHz system clock, all logic on rising edge
- reset  input  1  one clock; reset is asynchronous and active-high
- streamStart  input  1  sampled each cycle; starts a stream (sync preamble) in IDLE only
- streamStop  input  1  sampled each cycle; requests terminator in SYNC/ACTIVE
- dataOutput  input  64  word to transmit; byte [63:56] is sent first
- dataOutValid  input  1  word available
- dataOutReady  output  1  block accepts a word this cycle
- dataOut64Done  output  1  one-cycle pulse after the last stop bit of a data word
- fsm_state  output  2  IDLE=00, ACTIVE=01, SYNC=10, END=11
- byteCnt  output  4  bytes completed in current 8-byte burst, 0..8
- uart_tx_pin  output  1  serial line, idle high

## Operation
- Reset: fsm_state=IDLE, byteCnt=0, dataOutReady=0, dataOut64Done=0, uart_tx_pin=1, stop-pending flag cleared. Reset mid-byte truncates the byte; pin returns high immediately.
- Byte frame: start bit (0), 8 data bits LSB first, stop bit (1); each bit held exactly CPB cycles; 10·CPB cycles per byte. Bytes within a burst are back to back (no gap).
- IDLE: pin high. streamStart=1 → SYNC. streamStop, dataOutValid ignored. streamStart and streamStop both high → start wins.
- SYNC: sends 8 bytes 0xAA; then → END if stop pending, else → ACTIVE.
- ACTIVE: dataOutReady=1 when serialiser empty and no stop pending. Accept on edge with dataOutValid & dataOutReady: latch dataOutput, byteCnt=0, ready drops. After 8th byte, dataOut64Done pulses. If stop pending and serialiser empty → END.
- END: sends 8 bytes 0x55, then → IDLE, stop-pending cleared.
- streamStop in SYNC or ACTIVE sets stop-pending; it never aborts a burst in progress. Stop in END/IDLE ignored. streamStart outside IDLE ignored.
- No filtering of data: a word equal to 64'h5555555555555555 is sent as-is (receiver treats it as end-of-stream; caller's responsibility).
- byteCnt increments at end of each stop bit; cleared to 0 at start of each burst (sync, word, terminator); holds 8 between bursts until next burst starts.

## Timing
- streamStart high at edge k → after k: fsm_state=SYNC, uart_tx_pin=0 (first start bit).
- Accept at edge k → after k: uart_tx_pin=0, dataOutReady=0.
- Last stop bit ends at edge m → after m: byteCnt=8, dataOut64Done=1 for one cycle, dataOutReady=1 (if no stop pending), pin high.
- Back-to-back words with dataOutValid held high: next accept at edge m+1; exactly one extra idle-high cycle between words. Word period = 80·CPB+1 cycles.
- SYNC→ACTIVE and SYNC/ACTIVE→END transitions occur at edge m (no extra cycle); END→IDLE at edge m.
- dataOut64Done pulses only for data words, never for sync or terminator bursts.

## Test plan
- Reset: assert reset mid-byte (CLK_HZ=50e6, BIT_RATE=5e6, CPB=10) → pin=1, fsm_state=00, byteCnt=0, ready=0, done=0 asynchronously.
- Start: pulse streamStart in IDLE → decode 8 bytes 0xAA on pin over 800 cycles, then fsm_state=01, dataOutReady=1.
- Word: send 64'h0123456789ABCDEF → pin decodes 01,23,45,67,89,AB,CD,EF; each start bit exactly 10 cycles; dataOut64Done one cycle at 800 cycles after accept.
- Back-to-back: valid held high with two words → accepts spaced 801 cycles, exactly one idle-high cycle between bursts, two done pulses.
- Stop mid-word: streamStop asserted 300 cycles into a word → word completes, done pulses, then 8×0x55, then fsm_state=00; ready stays 0 after the word.
- Corner: streamStart+streamStop same cycle in IDLE → sync sent then ACTIVE (stop ignored); streamStop during SYNC → 8×0xAA then directly 8×0x55, no ready assertion.
